// File: rtl/pipeline_pkg.sv
// Shared execute-stage definitions: ALU opcodes, control-word and CCR bit
// positions, and the layout of the execute/memory boundary register.
package pipeline_pkg;

  localparam int unsigned DataW = 16;
  localparam int unsigned RegW  = 3;

  typedef enum logic [3:0] {
    AluNop  = 4'd0,
    AluNot  = 4'd1,
    AluInc  = 4'd2,
    AluDec  = 4'd3,
    AluMov  = 4'd4,
    AluAdd  = 4'd5,
    AluSub  = 4'd6,
    AluAnd  = 4'd7,
    AluOr   = 4'd8,
    AluShl  = 4'd9,
    AluShr  = 4'd10,
    AluSetc = 4'd11,
    AluClrc = 4'd12
  } alu_op_e;

  // Control word bit positions; [3:0] carry the ALU opcode.
  localparam int unsigned CtrlUseImm   = 4;
  localparam int unsigned CtrlRegWrite = 5;
  localparam int unsigned CtrlMemRead  = 6;
  localparam int unsigned CtrlMemWrite = 7;

  // CCR bit positions.
  localparam int unsigned CcrC = 2;
  localparam int unsigned CcrN = 1;
  localparam int unsigned CcrZ = 0;

  typedef struct packed {
    logic [DataW-1:0] result;
    logic [DataW-1:0] store_data;
    logic [RegW-1:0]  rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             valid;
  } exmem_t;

  function automatic logic is_mem_op(input logic [7:0] ctrl);
    return ctrl[CtrlMemRead] | ctrl[CtrlMemWrite];
  endfunction

endpackage

// File: rtl/exec_stage_if.sv
// Bundle of decode/execute inputs, pipeline controls and execute/memory
// outputs. master = upstream/downstream environment, slave = execute stage.
interface exec_stage_if;
  logic        in_valid;
  logic [15:0] Imm_value_execute;
  logic [4:0]  shmnt_execute;
  logic [15:0] Rs_data_execute;
  logic [15:0] Rd_data_execute;
  logic [2:0]  Rd_execute;
  logic [7:0]  control_signals_execute;
  logic        stall;
  logic        flush;

  logic [15:0] result_mem;
  logic [15:0] store_data_mem;
  logic [2:0]  Rd_mem;
  logic        reg_write_mem;
  logic        mem_read_mem;
  logic        mem_write_mem;
  logic        valid_mem;
  logic [2:0]  ccr;

  modport master (
    output in_valid, Imm_value_execute, shmnt_execute, Rs_data_execute, Rd_data_execute,
           Rd_execute, control_signals_execute, stall, flush,
    input  result_mem, store_data_mem, Rd_mem, reg_write_mem, mem_read_mem, mem_write_mem,
           valid_mem, ccr
  );

  modport slave (
    input  in_valid, Imm_value_execute, shmnt_execute, Rs_data_execute, Rd_data_execute,
           Rd_execute, control_signals_execute, stall, flush,
    output result_mem, store_data_mem, Rd_mem, reg_write_mem, mem_read_mem, mem_write_mem,
           valid_mem, ccr
  );
endinterface

// File: rtl/alu_16.sv
// Combinational 16-bit ALU/shifter: result plus candidate flags and a
// per-flag write mask ({C, N, Z} order, indexed by the CCR positions).
module alu_16
  import pipeline_pkg::*;
(
  input  alu_op_e     alu_op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [4:0]  shmnt_i,
  output logic [15:0] result_o,
  output logic [2:0]  flags_o,
  output logic [2:0]  flag_we_o
);

  logic [16:0] sum;
  logic [16:0] diff;
  logic [16:0] inc;
  logic [16:0] dec;
  logic [31:0] shl_w;
  logic [31:0] shr_w;
  logic        shm_zero;
  logic        shm_sixteen;
  logic        c_next;
  logic        zn_we;
  logic        c_we;

  // 17-bit arithmetic: bit 16 is carry-out for add/inc and borrow for sub/dec.
  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i};
    diff  = {1'b0, a_i} - {1'b0, b_i};
    inc   = {1'b0, a_i} + 17'd1;
    dec   = {1'b0, a_i} - 17'd1;
    // Bit 16 of shl_w / bit 15 of shr_w hold the last bit shifted out.
    shl_w = {16'b0, a_i} << shmnt_i;
    shr_w = {a_i, 16'b0} >> shmnt_i;
    shm_zero    = (shmnt_i == 5'd0);
    shm_sixteen = (shmnt_i == 5'd16);
  end

  // Opcode decode: result, carry candidate and which flags may be written.
  always_comb begin
    result_o = '0;
    c_next   = 1'b0;
    zn_we    = 1'b0;
    c_we     = 1'b0;
    case (alu_op_i)
      AluNot: begin
        result_o = ~a_i;
        zn_we    = 1'b1;
      end
      AluInc: begin
        {c_next, result_o} = inc;
        zn_we = 1'b1;
        c_we  = 1'b1;
      end
      AluDec: begin
        {c_next, result_o} = dec;
        zn_we = 1'b1;
        c_we  = 1'b1;
      end
      AluMov: begin
        result_o = b_i;
      end
      AluAdd: begin
        {c_next, result_o} = sum;
        zn_we = 1'b1;
        c_we  = 1'b1;
      end
      AluSub: begin
        {c_next, result_o} = diff;
        zn_we = 1'b1;
        c_we  = 1'b1;
      end
      AluAnd: begin
        result_o = a_i & b_i;
        zn_we    = 1'b1;
      end
      AluOr: begin
        result_o = a_i | b_i;
        zn_we    = 1'b1;
      end
      AluShl: begin
        result_o = shl_w[15:0];
        // A shift of exactly 16 reports the MSB of Rd as carry.
        c_next   = shm_sixteen ? a_i[15] : shl_w[16];
        zn_we    = 1'b1;
        c_we     = ~shm_zero;
      end
      AluShr: begin
        result_o = shr_w[31:16];
        // A shift of exactly 16 reports the LSB of Rd as carry.
        c_next   = shm_sixteen ? a_i[0] : shr_w[15];
        zn_we    = 1'b1;
        c_we     = ~shm_zero;
      end
      AluSetc: begin
        c_next = 1'b1;
        c_we   = 1'b1;
      end
      AluClrc: begin
        c_next = 1'b0;
        c_we   = 1'b1;
      end
      default: ;
    endcase
  end

  // Pack flags and write masks into CCR bit order.
  always_comb begin
    flags_o         = '0;
    flag_we_o       = '0;
    flags_o[CcrC]   = c_next;
    flags_o[CcrN]   = result_o[15];
    flags_o[CcrZ]   = (result_o == 16'h0000);
    flag_we_o[CcrC] = c_we;
    flag_we_o[CcrN] = zn_we;
    flag_we_o[CcrZ] = zn_we;
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand select, ALU/address generation, CCR and the
// execute/memory boundary register with stall/flush handling.
module exec_stage
  import pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  exec_stage_if.slave  bus
);

  logic [7:0]  ctrl;
  logic        mem_op;
  logic [15:0] operand_b;
  logic [15:0] addr;
  logic [15:0] alu_result;
  logic [2:0]  alu_flags;
  logic [2:0]  alu_we;

  exmem_t      out_q, out_d;
  logic [2:0]  ccr_q, ccr_d;

  // Operand selection and effective-address generation.
  always_comb begin
    ctrl      = bus.control_signals_execute;
    mem_op    = is_mem_op(ctrl);
    operand_b = ctrl[CtrlUseImm] ? bus.Imm_value_execute : bus.Rs_data_execute;
    addr      = bus.Rs_data_execute + bus.Imm_value_execute;
  end

  alu_16 u_alu (
    .alu_op_i  (alu_op_e'(ctrl[3:0])),
    .a_i       (bus.Rd_data_execute),
    .b_i       (operand_b),
    .shmnt_i   (bus.shmnt_execute),
    .result_o  (alu_result),
    .flags_o   (alu_flags),
    .flag_we_o (alu_we)
  );

  // Next boundary/CCR state: flush beats stall; stall holds; bubble zeroes.
  always_comb begin
    out_d = out_q;
    ccr_d = ccr_q;
    if (bus.flush || (!bus.stall && !bus.in_valid)) begin
      out_d = '0;
    end else if (!bus.stall) begin
      out_d.result     = mem_op ? addr : alu_result;
      out_d.store_data = bus.Rd_data_execute;
      out_d.rd         = bus.Rd_execute;
      out_d.reg_write  = ctrl[CtrlRegWrite];
      out_d.mem_read   = ctrl[CtrlMemRead];
      out_d.mem_write  = ctrl[CtrlMemWrite];
      out_d.valid      = 1'b1;
      if (!mem_op) begin
        ccr_d = (ccr_q & ~alu_we) | (alu_flags & alu_we);
      end
    end
  end

  // Boundary register and CCR; reset overrides stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      ccr_q <= '0;
    end else begin
      out_q <= out_d;
      ccr_q <= ccr_d;
    end
  end

  assign bus.result_mem     = out_q.result;
  assign bus.store_data_mem = out_q.store_data;
  assign bus.Rd_mem         = out_q.rd;
  assign bus.reg_write_mem  = out_q.reg_write;
  assign bus.mem_read_mem   = out_q.mem_read;
  assign bus.mem_write_mem  = out_q.mem_write;
  assign bus.valid_mem      = out_q.valid;
  assign bus.ccr            = ccr_q;

endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: directed vector table, hand sequences for stall,
// flush and reset, then random traffic against a behavioural model.
module tb_exec_stage;
  import pipeline_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exec_stage_if bus ();

  exec_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model of the visible state.
  logic [15:0] m_result, m_store;
  logic [2:0]  m_rd, m_ccr;
  logic        m_rw, m_mr, m_mw, m_valid, m_res_known;

  typedef struct {
    logic [7:0]  ctrl;
    logic [15:0] imm;
    logic [4:0]  shm;
    logic [15:0] rs;
    logic [15:0] rdd;
    logic [15:0] exp_res;
    logic        chk_res;
    logic [2:0]  exp_ccr;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [7:0] cw(input logic [3:0] op, input bit ui, input bit rw,
                                    input bit mr, input bit mw);
    return {mw, mr, rw, ui, op};
  endfunction

  function automatic vec_t mk(input logic [7:0] c, input logic [15:0] imm, input logic [4:0] shm,
                              input logic [15:0] rs, input logic [15:0] rdd,
                              input logic [15:0] er, input bit cr, input logic [2:0] ec);
    vec_t v;
    v.ctrl = c; v.imm = imm; v.shm = shm; v.rs = rs; v.rdd = rdd;
    v.exp_res = er; v.chk_res = cr; v.exp_ccr = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] c, input logic [15:0] imm,
                       input logic [4:0] sh, input logic [15:0] rs, input logic [15:0] rdd,
                       input logic [2:0] rdi, input bit st, input bit fl);
    bus.in_valid                = v;
    bus.control_signals_execute = c;
    bus.Imm_value_execute       = imm;
    bus.shmnt_execute           = sh;
    bus.Rs_data_execute         = rs;
    bus.Rd_data_execute         = rdd;
    bus.Rd_execute              = rdi;
    bus.stall                   = st;
    bus.flush                   = fl;
  endtask

  task automatic drive_random(input bit with_ctl);
    logic [7:0] c;
    c = 8'($urandom);
    // Keep memory ops to roughly a quarter of traffic.
    if ($urandom_range(3) != 0) c[7:6] = 2'b00;
    drive(($urandom_range(9) < 8), c, 16'($urandom), 5'($urandom), 16'($urandom),
          16'($urandom), 3'($urandom),
          with_ctl && ($urandom_range(4) == 0), with_ctl && ($urandom_range(9) == 0));
  endtask

  // Next expected state from the instruction rules, using plain integers.
  task automatic model_step();
    int unsigned a, b, rs, imm, r, n, v;
    int unsigned op;
    bit c, zn_upd, c_upd, is_shl;
    logic [7:0] ctl;
    ctl = bus.control_signals_execute;
    if (rst) begin
      {m_result, m_store, m_rd, m_rw, m_mr, m_mw, m_valid, m_ccr} = '0;
      m_res_known = 1'b1;
    end else if (bus.flush || (!bus.stall && !bus.in_valid)) begin
      {m_result, m_store, m_rd, m_rw, m_mr, m_mw, m_valid} = '0;
      m_res_known = 1'b1;
    end else if (!bus.stall) begin
      a   = bus.Rd_data_execute;
      rs  = bus.Rs_data_execute;
      imm = bus.Imm_value_execute;
      b   = ctl[4] ? imm : rs;
      op  = ctl[3:0];
      r = 0; c = 0; zn_upd = 0; c_upd = 0;
      m_res_known = 1'b1;
      if (ctl[6] || ctl[7]) begin
        r = (rs + imm) % 65536;
      end else begin
        case (op)
          1: begin r = 65535 - a; zn_upd = 1; end
          2: begin r = (a + 1) % 65536; c = (a + 1 > 65535); zn_upd = 1; c_upd = 1; end
          3: begin r = (a + 65535) % 65536; c = (a == 0); zn_upd = 1; c_upd = 1; end
          4: r = b;
          5: begin r = (a + b) % 65536; c = (a + b > 65535); zn_upd = 1; c_upd = 1; end
          6: begin r = (a + 65536 - b) % 65536; c = (a < b); zn_upd = 1; c_upd = 1; end
          7: begin r = a & b; zn_upd = 1; end
          8: begin r = a | b; zn_upd = 1; end
          9, 10: begin
            is_shl = (op == 9);
            n = bus.shmnt_execute;
            zn_upd = 1;
            if (n == 0) begin
              r = a;
            end else if (n < 16) begin
              v = a;
              for (int i = 0; i < 32; i++) begin
                if (i < int'(n)) begin
                  if (is_shl) begin c = v[15]; v = (v << 1) % 65536; end
                  else begin c = v[0]; v = v >> 1; end
                end
              end
              r = v; c_upd = 1;
            end else begin
              r = 0; c_upd = 1;
              c = (n == 16) ? (is_shl ? a[15] : a[0]) : 1'b0;
            end
          end
          11: begin c = 1; c_upd = 1; end
          12: begin c = 0; c_upd = 1; end
          default: m_res_known = 1'b0;
        endcase
        if (op == 11 || op == 12) m_res_known = 1'b0;
      end
      if (zn_upd) begin
        m_ccr[0] = (r == 0);
        m_ccr[1] = (r >= 32768);
      end
      if (c_upd) m_ccr[2] = c;
      m_result = r[15:0];
      m_store  = bus.Rd_data_execute;
      m_rd     = bus.Rd_execute;
      m_rw     = ctl[5];
      m_mr     = ctl[6];
      m_mw     = ctl[7];
      m_valid  = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, bus.valid_mem, m_valid);
    chk({tag, ".reg_write"}, bus.reg_write_mem, m_rw);
    chk({tag, ".mem_read"}, bus.mem_read_mem, m_mr);
    chk({tag, ".mem_write"}, bus.mem_write_mem, m_mw);
    chk({tag, ".ccr"}, bus.ccr, m_ccr);
    chk({tag, ".rd"}, bus.Rd_mem, m_rd);
    chk({tag, ".store"}, bus.store_data_mem, m_store);
    if (m_res_known) chk({tag, ".result"}, bus.result_mem, m_result);
  endtask

  // Advance one clock with the model; sample 1 time unit after the edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    vecs[0]  = mk(cw(AluAdd, 0, 1, 0, 0), 16'h0000, 5'd0, 16'h0001, 16'h7FFF, 16'h8000, 1, 3'b010);
    vecs[1]  = mk(cw(AluSub, 1, 1, 0, 0), 16'h0005, 5'd0, 16'h0000, 16'h0005, 16'h0000, 1, 3'b001);
    vecs[2]  = mk(cw(AluDec, 0, 1, 0, 0), 16'h0000, 5'd0, 16'h0000, 16'h0000, 16'hFFFF, 1, 3'b110);
    vecs[3]  = mk(cw(AluShl, 0, 1, 0, 0), 16'h0000, 5'd1, 16'h0000, 16'h8001, 16'h0002, 1, 3'b100);
    vecs[4]  = mk(cw(AluShr, 0, 1, 0, 0), 16'h0000, 5'd17, 16'h0000, 16'h0003, 16'h0000, 1, 3'b001);
    vecs[5]  = mk(cw(AluNop, 0, 0, 0, 1), 16'h0010, 5'd0, 16'h0100, 16'hBEEF, 16'h0110, 1, 3'b001);
    vecs[6]  = mk(cw(AluInc, 0, 1, 0, 0), 16'h0000, 5'd0, 16'h0000, 16'hFFFF, 16'h0000, 1, 3'b101);
    vecs[7]  = mk(cw(AluMov, 1, 1, 0, 0), 16'h1234, 5'd0, 16'h0000, 16'h0000, 16'h1234, 1, 3'b101);
    vecs[8]  = mk(cw(AluClrc, 0, 0, 0, 0), 16'h0000, 5'd0, 16'h0000, 16'h0000, 16'h0000, 0, 3'b001);
    vecs[9]  = mk(cw(AluShl, 0, 1, 0, 0), 16'h0000, 5'd16, 16'h0000, 16'h8000, 16'h0000, 1, 3'b101);
    vecs[10] = mk(cw(AluClrc, 0, 0, 0, 0), 16'h0000, 5'd0, 16'h0000, 16'h0000, 16'h0000, 0, 3'b001);
    vecs[11] = mk(cw(AluShr, 0, 1, 0, 0), 16'h0000, 5'd16, 16'h0000, 16'h0001, 16'h0000, 1, 3'b101);
    vecs[12] = mk(cw(AluShl, 0, 1, 0, 0), 16'h0000, 5'd0, 16'h0000, 16'h8000, 16'h8000, 1, 3'b110);
    vecs[13] = mk(cw(AluNot, 0, 1, 0, 0), 16'h0000, 5'd0, 16'h0000, 16'h00FF, 16'hFF00, 1, 3'b110);
    vecs[14] = mk(cw(AluAnd, 0, 1, 0, 0), 16'h0000, 5'd0, 16'h0FF0, 16'hF0F0, 16'h00F0, 1, 3'b100);
    vecs[15] = mk(cw(AluOr, 0, 1, 0, 0), 16'h0000, 5'd0, 16'h0000, 16'h0000, 16'h0000, 1, 3'b101);
    vecs[16] = mk(cw(AluSub, 0, 1, 0, 0), 16'h0000, 5'd0, 16'h0005, 16'h0003, 16'hFFFE, 1, 3'b110);
    vecs[17] = mk(cw(4'd14, 0, 1, 0, 0), 16'h0000, 5'd0, 16'h0000, 16'h1111, 16'h0000, 0, 3'b110);
    vecs[18] = mk(cw(AluAdd, 0, 1, 1, 0), 16'h0020, 5'd0, 16'hFFF0, 16'h0000, 16'h0010, 1, 3'b110);
    vecs[19] = mk(cw(AluShr, 0, 1, 0, 0), 16'h0000, 5'd15, 16'h0000, 16'h8000, 16'h0001, 1, 3'b000);

    // Reset held two cycles with random inputs.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_random(1'b1);
      tick("reset");
      chk("reset.result", bus.result_mem, 16'h0000);
      chk("reset.valid", bus.valid_mem, 1'b0);
      chk("reset.ccr", bus.ccr, 3'b000);
    end
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, vecs[i].ctrl, vecs[i].imm, vecs[i].shm, vecs[i].rs, vecs[i].rdd, 3'(i),
            1'b0, 1'b0);
      tick($sformatf("vec%0d", i));
      if (vecs[i].chk_res) chk($sformatf("vec%0d.result", i), bus.result_mem, vecs[i].exp_res);
      chk($sformatf("vec%0d.ccr", i), bus.ccr, vecs[i].exp_ccr);
      chk($sformatf("vec%0d.store", i), bus.store_data_mem, vecs[i].rdd);
      chk($sformatf("vec%0d.valid", i), bus.valid_mem, 1'b1);
      chk($sformatf("vec%0d.mem_write", i), bus.mem_write_mem, vecs[i].ctrl[7]);
    end

    // ADD held by stall for three cycles: last result 0x0001 / ccr 000 frozen.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, cw(AluAdd, 0, 1, 0, 0), 16'h0, 5'd0, 16'h0001, 16'hFFFF, 3'd5, 1'b1, 1'b0);
      tick("stall");
      chk("stall.result", bus.result_mem, 16'h0001);
      chk("stall.ccr", bus.ccr, 3'b000);
      chk("stall.valid", bus.valid_mem, 1'b1);
    end
    drive(1'b1, cw(AluAdd, 0, 1, 0, 0), 16'h0, 5'd0, 16'h0001, 16'hFFFF, 3'd5, 1'b0, 1'b0);
    tick("release");
    chk("release.result", bus.result_mem, 16'h0000);
    chk("release.ccr", bus.ccr, 3'b101);

    // Clear C, then flush+stall an overflowing ADD: no CCR change, bubble out.
    drive(1'b1, cw(AluClrc, 0, 0, 0, 0), 16'h0, 5'd0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
    tick("clrc");
    chk("clrc.ccr", bus.ccr, 3'b001);
    drive(1'b1, cw(AluAdd, 0, 1, 0, 0), 16'h0, 5'd0, 16'h0001, 16'hFFFF, 3'd7, 1'b1, 1'b1);
    tick("flush");
    chk("flush.valid", bus.valid_mem, 1'b0);
    chk("flush.reg_write", bus.reg_write_mem, 1'b0);
    chk("flush.result", bus.result_mem, 16'h0000);
    chk("flush.ccr", bus.ccr, 3'b001);

    // in_valid low with write controls set: bubble.
    drive(1'b0, cw(AluAdd, 0, 1, 1, 1), 16'h0, 5'd0, 16'h0001, 16'hFFFF, 3'd7, 1'b0, 1'b0);
    tick("bubble");
    chk("bubble.mem_write", bus.mem_write_mem, 1'b0);
    chk("bubble.ccr", bus.ccr, 3'b001);

    // Load something, then reset while stalled: reset must win.
    drive(1'b1, cw(AluSetc, 0, 1, 0, 0), 16'h0, 5'd0, 16'h0, 16'h0, 3'd3, 1'b0, 1'b0);
    tick("setc");
    chk("setc.ccr", bus.ccr, 3'b101);
    rst = 1'b1;
    drive(1'b1, cw(AluAdd, 0, 1, 0, 0), 16'h0, 5'd0, 16'h0001, 16'h0001, 3'd3, 1'b1, 1'b0);
    tick("rst_stall");
    chk("rst_stall.valid", bus.valid_mem, 1'b0);
    chk("rst_stall.ccr", bus.ccr, 3'b000);
    rst = 1'b0;

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      drive_random(1'b1);
      rst = ($urandom_range(99) == 0);
      tick("rand");
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage of the 16-bit five-stage pipeline. It consumes the operands and 8-bit control word from the decode/execute register, performs the ALU, shift or address operation, maintains the condition-code register (CCR: Z, N, C), and registers the results into the execute/memory boundary. Downstream stall and flush requests are honoured cycle-exactly.

## Interface
- No parameters; datapath fixed at 16 bits, register index 3 bits.
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode/execute register holds a real instruction
- Imm_value_execute  in  16  immediate operand
- shmnt_execute  in  5  shift amount
- Rs_data_execute  in  16  source register value
- Rd_data_execute  in  16  destination register value (first operand, store data)
- Rd_execute  in  3  destination register index
- control_signals_execute  in  8  [3:0] alu_op, [4] use_imm, [5] reg_write, [6] mem_read, [7] mem_write
- stall  in  1  memory stage cannot accept; hold all outputs and CCR
- flush  in  1  squash the instruction currently in execute
- result_mem  out  16  ALU result or effective address
- store_data_mem  out  16  Rd_data_execute captured for stores
- Rd_mem  out  3  destination index
- reg_write_mem, mem_read_mem, mem_write_mem  out  1 each  forwarded controls
- valid_mem  out  1  output slot holds a real instruction
- ccr  out  3  {C, N, Z}

## Operation
- Operand B = use_imm ? Imm_value_execute : Rs_data_execute.
- alu_op: 0 NOP, 1 NOT Rd, 2 INC Rd, 3 DEC Rd, 4 MOV B, 5 ADD Rd+B, 6 SUB Rd−B, 7 AND, 8 OR, 9 SHL Rd by shmnt, 10 SHR Rd by shmnt (logical), 11 SETC, 12 CLRC, 13–15 reserved and treated as NOP.
- mem_read or mem_write set: result = Rs_data_execute + Imm_value_execute (address); alu_op ignored; CCR unchanged.
- Arithmetic is 17 bits internally; C = bit 16 for ADD/INC; for SUB/DEC, C = borrow (1 when Rd < B unsigned, or Rd == 0 for DEC).
- Shifts: C = last bit shifted out; shmnt 0 leaves result = Rd with C unchanged; shmnt ≥ 16 gives result 0, and C = Rd[0] (SHR) or Rd[15] (SHL) only when shmnt == 16, otherwise 0.
- Z/N are updated from the result by ops 1–10 (except MOV, which leaves CCR); C is updated by 2,3,5,6,9,10,11,12 only. NOP/reserved leave CCR.
- CCR updates only when in_valid=1, stall=0, flush=0.

## Timing
- Latency one cycle: inputs sampled at posedge N appear on *_mem outputs after posedge N.
- Reset (rst=1 at posedge): all outputs 0, ccr=3'b000, valid_mem=0; rst overrides stall and flush.
- stall=1, flush=0: every output and CCR hold; the input is not consumed (upstream holds it).
- flush=1: next cycle valid_mem=0 and reg_write/mem_read/mem_write=0; data outputs are don't-care but are driven 0; CCR is not updated. flush wins over stall.
- in_valid=0 (no flush/stall): bubble emitted exactly as for flush.
- Control outputs are gated by valid; a bubble never asserts a write.

## Structure
- Shared package pipeline_pkg: ALU opcode constants, control-word bit positions, CCR bit positions (C=2, N=1, Z=0).
- Sub-module alu_16: combinational op/operand/shift → result + next flags + flag-write masks; exec_stage owns all registers and stall/flush logic.

## Test plan
- rst held 2 cycles with random inputs → all outputs 0, ccr 000; release, ADD Rd=0x7FFF B=Rs=0x0001 → result 0x8000, ccr {C0,N1,Z0}.
- SUB Rd=0x0005 use_imm Imm=0x0005 → result 0x0000, ccr {0,0,1}; DEC Rd=0x0000 → 0xFFFF, ccr {1,1,0}.
- SHL Rd=0x8001 shmnt=1 → 0x0002, C=1; SHR Rd=0x0003 shmnt=17 → 0x0000, C=0, Z=1.
- STD: mem_write=1 Rs=0x0100 Imm=0x0010 Rd_data=0xBEEF → result 0x0110, store_data 0xBEEF, mem_write_mem=1, ccr unchanged.
- ADD issued with stall=1 for 3 cycles → outputs and ccr frozen at previous values; after release ADD result appears one cycle later.
- ADD 0xFFFF+1 with flush=1 and stall=1 together → valid_mem=0, all write controls 0, ccr unchanged (C not set).
